// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;
    localparam int ADDR_W_DEFAULT = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, loader and RAM buses seen by the arbiter
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;

    logic              ld_req;
    logic              ld_we;
    logic              ld_lock;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic [31:0]       ld_rdata;
    logic              ld_ack;
    logic              ld_err;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err,
        input  ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
        output ld_rdata, ld_ack, ld_err,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err,
        output ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
        input  ld_rdata, ld_ack, ld_err,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_port_reg.sv
// rtl/dmem_port_reg.sv - per-requester operand latch and read-data capture
module dmem_port_reg #(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          latch_en,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic          cap_en,
    input  logic [31:0]   ram_rdata,
    output logic          lat_we,
    output logic [AW-1:0] lat_addr,
    output logic [31:0]   lat_wdata,
    output logic [31:0]   rdata
);
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          unused_addr_hi;

    // Only the word index and byte offset matter; higher address bits are ignored.
    assign unused_addr_hi = ^req_addr[31:AW];

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (latch_en) begin
            we_d    = req_we;
            addr_d  = req_addr[AW-1:0];
            wdata_d = req_wdata;
        end
        if (cap_en) begin
            rdata_d = ram_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign lat_we    = we_q;
    assign lat_addr  = addr_q;
    assign lat_wdata = wdata_q;
    assign rdata     = rdata_q;
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin CPU/loader arbiter for a single-port data RAM
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    dmem_arbiter_if.slave   bus,
    output logic            busy
);
    localparam int AW = ADDR_W + 2;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        pick;
    logic          last_ld_q, last_ld_d;
    logic          cpu_grant, ld_grant;

    logic          cpu_lat_we, ld_lat_we, sel_we;
    logic [AW-1:0] cpu_lat_addr, ld_lat_addr, sel_addr;
    logic [31:0]   cpu_lat_wdata, ld_lat_wdata;
    logic          misaligned;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_ld_d = last_ld_q;
        cpu_grant = 1'b0;
        ld_grant  = 1'b0;
        pick      = OWN_CPU;
        // On a tie the port not granted last wins, unless a locked loader keeps the RAM.
        if (bus.cpu_req && bus.ld_req) begin
            pick = (last_ld_q && !bus.ld_lock) ? OWN_CPU : OWN_LD;
        end else if (bus.ld_req) begin
            pick = OWN_LD;
        end
        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.ld_req) begin
                    state_d   = ACCESS;
                    owner_d   = pick;
                    last_ld_d = (pick == OWN_LD);
                    cpu_grant = (pick == OWN_CPU);
                    ld_grant  = (pick == OWN_LD);
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_CPU;
            last_ld_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_ld_q <= last_ld_d;
        end
    end

    dmem_port_reg #(.AW(AW)) u_cpu_port (
        .clock     (clock),
        .reset_n   (reset_n),
        .latch_en  (cpu_grant),
        .req_we    (bus.cpu_we),
        .req_addr  (bus.cpu_addr),
        .req_wdata (bus.cpu_wdata),
        .cap_en    (state_q == ACCESS && owner_q == OWN_CPU),
        .ram_rdata (bus.ram_rdata),
        .lat_we    (cpu_lat_we),
        .lat_addr  (cpu_lat_addr),
        .lat_wdata (cpu_lat_wdata),
        .rdata     (bus.cpu_rdata)
    );

    dmem_port_reg #(.AW(AW)) u_ld_port (
        .clock     (clock),
        .reset_n   (reset_n),
        .latch_en  (ld_grant),
        .req_we    (bus.ld_we),
        .req_addr  (bus.ld_addr),
        .req_wdata (bus.ld_wdata),
        .cap_en    (state_q == ACCESS && owner_q == OWN_LD),
        .ram_rdata (bus.ram_rdata),
        .lat_we    (ld_lat_we),
        .lat_addr  (ld_lat_addr),
        .lat_wdata (ld_lat_wdata),
        .rdata     (bus.ld_rdata)
    );

    // The latches only move on a grant, so the owner mux also holds the RAM bus between accesses.
    assign sel_we     = (owner_q == OWN_LD) ? ld_lat_we   : cpu_lat_we;
    assign sel_addr   = (owner_q == OWN_LD) ? ld_lat_addr : cpu_lat_addr;
    assign misaligned = |sel_addr[1:0];

    assign bus.ram_addr  = sel_addr[AW-1:2];
    assign bus.ram_wdata = (owner_q == OWN_LD) ? ld_lat_wdata : cpu_lat_wdata;
    // reset_n gates the strobe directly so an aborted write never reaches the RAM.
    assign bus.ram_we    = reset_n && (state_q == ACCESS) && sel_we && !misaligned;

    assign bus.cpu_ack = (state_q == RESP) && (owner_q == OWN_CPU);
    assign bus.ld_ack  = (state_q == RESP) && (owner_q == OWN_LD);
    assign bus.cpu_err = bus.cpu_ack && misaligned;
    assign bus.ld_err  = bus.ld_ack && misaligned;
    assign busy        = (state_q != IDLE);
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width driven to the data RAM.
REQ-002 SHALL have ports: clock in 1, system clock, all state on rising edge.
REQ-003 SHALL have port: reset_n in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: cpu_req in 1, cpu_we in 1, cpu_addr in 32 (byte address), cpu_wdata in 32 (CPU requester).
REQ-005 SHALL have ports: cpu_rdata out 32, cpu_ack out 1, cpu_err out 1 (CPU response).
REQ-006 SHALL have ports: ld_req, ld_we, ld_lock in 1 each, ld_addr in 32, ld_wdata in 32 (UART program-loader requester).
REQ-007 SHALL have ports: ld_rdata out 32, ld_ack out 1, ld_err out 1 (loader response).
REQ-008 SHALL have ports: ram_we out 1, ram_addr out ADDR_W, ram_wdata out 32, ram_rdata in 32 (single-port RAM, one-cycle read, data valid by end of the addressed cycle).
REQ-009 SHALL have port: busy out 1, high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one access in flight at a time.
REQ-011 IDLE: if any req is high, SHALL select an owner, latch its we/addr/wdata and go to ACCESS; otherwise stay in IDLE.
REQ-012 Selection SHALL be round-robin: with both reqs high, the port not granted last wins; last-granted resets to loader, so CPU wins the first tie.
REQ-013 If ld_lock=1 and the loader was granted last, the loader SHALL win every tie regardless of round-robin.
REQ-014 ACCESS: ram_addr SHALL equal latched addr[ADDR_W+1:2], ram_wdata the latched wdata, and ram_we SHALL equal latched we AND addr[1:0]==0.
REQ-015 ram_we SHALL be 0 in every state except ACCESS; ram_addr/ram_wdata hold their last values outside ACCESS.
REQ-016 At the end of ACCESS, ram_rdata SHALL be captured into the owner's rdata register; reads and writes both capture.
REQ-017 RESP: owner's ack SHALL pulse exactly one cycle; the non-owner's ack stays 0.
REQ-018 err SHALL pulse with ack when latched addr[1:0]!=0; the write is suppressed; rdata is still updated.
REQ-019 Latency SHALL be: req sampled in IDLE at cycle N, ACCESS N+1, ack N+2; back-to-back throughput is one access per 3 cycles.
REQ-020 Requesters SHALL hold req and operands stable until ack; req still high in the cycle after RESP SHALL start a new access.
REQ-021 rdata outputs SHALL hold their value until the next access by the same port.
REQ-022 A change to cpu_*/ld_* inputs during ACCESS or RESP SHALL NOT alter the in-flight access.

Reset
REQ-023 reset_n=0 SHALL immediately force state IDLE, ram_we=0, acks/errs=0, busy=0, rdata=0, ram_addr=0, ram_wdata=0, last-granted=loader.
REQ-024 Reset asserted during ACCESS SHALL abort the write combinationally (ram_we low without waiting for a clock edge); no ack is issued for the aborted access.
REQ-025 After reset_n deasserts, arbitration SHALL resume on the first rising edge.

Structure
REQ-026 Package dmem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the owner encoding (OWN_CPU/OWN_LD) and the ADDR_W default.
REQ-027 Sub-module dmem_port_reg (request latch plus rdata capture per requester) SHALL be instantiated twice; the FSM and round-robin logic stay in the top level.

Verification
REQ-028 CPU write addr 0x0000_0010, data 0xDEAD_BEEF -> ram_we=1 with ram_addr=4 in cycle N+1, cpu_ack at N+2, cpu_err=0.
REQ-029 CPU read addr 0x10 after the write (RAM model returns 0xDEAD_BEEF) -> cpu_rdata=0xDEAD_BEEF with cpu_ack at N+2.
REQ-030 Both reqs held high for 4 accesses, ld_lock=0 -> grant order CPU, LD, CPU, LD; each ack 3 cycles apart.
REQ-031 Both reqs high, ld_lock=1 after a loader grant -> 3 consecutive loader acks, cpu_ack stays 0 until ld_lock drops.
REQ-032 Loader write addr 0x0000_0006 -> ram_we stays 0, ld_ack=1 and ld_err=1 in the same cycle.
REQ-033 reset_n pulled low mid-ACCESS of a write -> ram_we drops to 0 before the next edge, state IDLE, no ack; a subsequent CPU read completes normally.
